// File: rtl/idit8_engine.sv
// 8-point radix-2 DIT inverse FFT built around one shared butterfly, stepped 3 stages x 4 butterflies.
// Results are the working bank scaled by 1/8, saturated to DW bits and registered per output sample.

module idit8_out_lane #(
  parameter int DW = 17,
  parameter int IW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_i,
  input  logic [IW-1:0] acc_re_i,
  input  logic [IW-1:0] acc_im_i,
  output logic [DW-1:0] y_re_o,
  output logic [DW-1:0] y_im_o
);
  localparam logic signed [IW-1:0] MAXV = IW'((2 ** (DW - 1)) - 1);
  localparam logic signed [IW-1:0] MINV = -MAXV - IW'(1);

  function automatic logic [DW-1:0] scale_sat(input logic [IW-1:0] v);
    logic signed [IW-1:0] sh;
    sh = $signed(v) >>> 3;
    if (sh > MAXV)      scale_sat = DW'(MAXV);
    else if (sh < MINV) scale_sat = DW'(MINV);
    else                scale_sat = DW'(sh);
  endfunction

  logic [DW-1:0] y_re_q, y_re_d, y_im_q, y_im_d;

  assign y_re_d = ld_i ? scale_sat(acc_re_i) : y_re_q;
  assign y_im_d = ld_i ? scale_sat(acc_im_i) : y_im_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      y_re_q <= '0;
      y_im_q <= '0;
    end else begin
      y_re_q <= y_re_d;
      y_im_q <= y_im_d;
    end
  end

  assign y_re_o = y_re_q;
  assign y_im_o = y_im_q;
endmodule

module idit8_engine #(
  parameter int DW = 17,
  parameter int IW = 20,
  parameter int TW = 18
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [8*DW-1:0] x_re,
  input  logic [8*DW-1:0] x_im,
  output logic            busy,
  output logic            done,
  output logic [8*DW-1:0] y_re,
  output logic [8*DW-1:0] y_im
);
  localparam int PW = IW + TW;
  localparam logic signed [TW-1:0] W_ONE = TW'(65536);
  localparam logic signed [TW-1:0] W_R2  = TW'(46340);

  typedef enum logic [1:0] {S_IDLE, S_STAGE, S_OUTPUT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        s_q, s_d, b_q, b_d;
  logic [7:0][IW-1:0] re_q, re_d, im_q, im_d;
  logic [7:0][IW-1:0] ld_re, ld_im;
  logic              done_q, done_d;
  logic              y_ld;

  // Bank is loaded in bit-reversed order so the butterflies run in place.
  for (genvar g = 0; g < 8; g++) begin : g_load
    localparam int R = ((g & 1) << 2) | (g & 2) | ((g >> 2) & 1);
    assign ld_re[g] = IW'($signed(x_re[R*DW +: DW]));
    assign ld_im[g] = IW'($signed(x_im[R*DW +: DW]));
  end

  logic [2:0] top, bot;
  logic [1:0] k;

  always_comb begin
    top = '0;
    bot = '0;
    k   = '0;
    case (s_q)
      2'd0: begin
        top = {b_q, 1'b0};
        bot = {b_q, 1'b1};
        k   = 2'd0;
      end
      2'd1: begin
        top = {b_q[1], 1'b0, b_q[0]};
        bot = {b_q[1], 1'b1, b_q[0]};
        k   = {b_q[0], 1'b0};
      end
      default: begin
        top = {1'b0, b_q};
        bot = {1'b1, b_q};
        k   = b_q;
      end
    endcase
  end

  // Inverse twiddles: W(k) = cos(pi*k/4) + j*sin(pi*k/4), Q2.16.
  logic signed [TW-1:0] wr, wi;

  always_comb begin
    wr = W_ONE;
    wi = '0;
    case (k)
      2'd0: begin wr = W_ONE;  wi = '0;    end
      2'd1: begin wr = W_R2;   wi = W_R2;  end
      2'd2: begin wr = '0;     wi = W_ONE; end
      default: begin wr = -W_R2; wi = W_R2; end
    endcase
  end

  logic signed [IW-1:0] ar, ai;
  logic signed [PW:0]   ar_x, ai_x, wr_x, wi_x, mr, mi;
  logic [IW-1:0]        tr, ti, sum_re, sum_im, dif_re, dif_im;

  assign ar   = $signed(re_q[bot]);
  assign ai   = $signed(im_q[bot]);
  assign ar_x = (PW+1)'(ar);
  assign ai_x = (PW+1)'(ai);
  assign wr_x = (PW+1)'(wr);
  assign wi_x = (PW+1)'(wi);
  assign mr   = ar_x * wr_x - ai_x * wi_x;
  assign mi   = ar_x * wi_x + ai_x * wr_x;
  // Arithmetic shift floors toward -inf before wrapping to IW.
  assign tr   = IW'(mr >>> 16);
  assign ti   = IW'(mi >>> 16);

  assign sum_re = re_q[top] + tr;
  assign sum_im = im_q[top] + ti;
  assign dif_re = re_q[top] - tr;
  assign dif_im = im_q[top] - ti;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    re_d    = re_q;
    im_d    = im_q;
    done_d  = 1'b0;
    y_ld    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          re_d    = ld_re;
          im_d    = ld_im;
          s_d     = '0;
          b_d     = '0;
          state_d = S_STAGE;
        end
      end
      S_STAGE: begin
        re_d[top] = sum_re;
        im_d[top] = sum_im;
        re_d[bot] = dif_re;
        im_d[bot] = dif_im;
        b_d       = b_q + 2'd1;
        if (b_q == 2'd3) begin
          if (s_q == 2'd2) begin
            s_d     = '0;
            state_d = S_OUTPUT;
          end else begin
            s_d = s_q + 2'd1;
          end
        end
      end
      S_OUTPUT: begin
        y_ld    = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      b_q     <= '0;
      re_q    <= '0;
      im_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      re_q    <= re_d;
      im_q    <= im_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

  for (genvar n = 0; n < 8; n++) begin : g_lane
    idit8_out_lane #(.DW(DW), .IW(IW)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .ld_i     (y_ld),
      .acc_re_i (re_q[n]),
      .acc_im_i (im_q[n]),
      .y_re_o   (y_re[n*DW +: DW]),
      .y_im_o   (y_im[n*DW +: DW])
    );
  end
endmodule

// File: tb/tb_idit8_engine.sv
// Directed-vector bench for idit8_engine with bit-exact hand-computed results.

module tb_idit8_engine;
  localparam int DW = 17;
  typedef logic [8*DW-1:0] vec_t;

  logic clk = 1'b0;
  logic reset, start, busy, done;
  vec_t x_re, x_im, y_re, y_im;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   lat, seen;

  idit8_engine dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x_re  (x_re),
    .x_im  (x_im),
    .busy  (busy),
    .done  (done),
    .y_re  (y_re),
    .y_im  (y_im)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic vec_t pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int   a[8];
    vec_t r;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    r = '0;
    for (int i = 0; i < 8; i++) r[i*DW +: DW] = DW'(a[i]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input vec_t xr, input vec_t xi, output int n);
    x_re  = xr;
    x_im  = xi;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, vec_t'(busy), vec_t'(1));
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 40);
    check({tag, "_lat"}, vec_t'(n), vec_t'(13));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    x_re  = '0;
    x_im  = '0;
    tick();
    tick();
    check("rst_busy", vec_t'(busy), vec_t'(0));
    check("rst_done", vec_t'(done), vec_t'(0));
    check("rst_yre", y_re, '0);
    check("rst_yim", y_im, '0);
    reset = 1'b0;
    tick();

    // Impulse
    run("imp", pk(8000, 0, 0, 0, 0, 0, 0, 0), '0, lat);
    check("imp_yre", y_re, pk(1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000));
    check("imp_yim", y_im, '0);
    tick();
    check("imp_pulse", vec_t'(done), vec_t'(0));
    check("imp_idle", vec_t'(busy), vec_t'(0));

    // DC
    run("dc", pk(800, 800, 800, 800, 800, 800, 800, 800), '0, lat);
    check("dc_yre", y_re, pk(800, 0, 0, 0, 0, 0, 0, 0));
    check("dc_yim", y_im, '0);

    // Single tone in bin 1; -5657>>>3 floors to -708
    run("tone", pk(0, 8000, 0, 0, 0, 0, 0, 0), '0, lat);
    check("tone_yre", y_re, pk(1000, 707, 0, -708, -1000, -707, 0, 707));
    check("tone_yim", y_im, pk(0, 707, 1000, 707, 0, -707, -1000, -707));

    // Full-scale negative DC lands exactly on the IW minimum
    run("ext", pk(-65536, -65536, -65536, -65536, -65536, -65536, -65536, -65536),
        pk(-65536, -65536, -65536, -65536, -65536, -65536, -65536, -65536), lat);
    check("ext_yre", y_re, pk(-65536, 0, 0, 0, 0, 0, 0, 0));
    check("ext_yim", y_im, pk(-65536, 0, 0, 0, 0, 0, 0, 0));

    // Handshake: start held 20 cycles, x changed mid-run
    x_re  = pk(8000, 0, 0, 0, 0, 0, 0, 0);
    x_im  = '0;
    start = 1'b1;
    tick();
    check("hs_busy", vec_t'(busy), vec_t'(1));
    x_re = pk(800, 800, 800, 800, 800, 800, 800, 800);
    lat  = 0;
    do begin
      tick();
      lat++;
    end while (!done && lat < 40);
    check("hs_lat1", vec_t'(lat), vec_t'(13));
    check("hs_y1", y_re, pk(1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000));
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 6) start = 1'b0;
    end while (!done && lat < 40);
    check("hs_lat2", vec_t'(lat), vec_t'(14));
    check("hs_y2re", y_re, pk(800, 0, 0, 0, 0, 0, 0, 0));
    check("hs_y2im", y_im, '0);
    tick();
    check("hs_noq", vec_t'(busy), vec_t'(0));

    // Reset mid-run at T+6
    x_re  = pk(0, 8000, 0, 0, 0, 0, 0, 0);
    x_im  = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("ab_busy_pre", vec_t'(busy), vec_t'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ab_busy", vec_t'(busy), vec_t'(0));
    check("ab_yre", y_re, '0);
    check("ab_yim", y_im, '0);
    seen = 0;
    repeat (12) begin
      if (done) seen++;
      tick();
    end
    check("ab_nodone", vec_t'(seen), vec_t'(0));
    run("fresh", pk(8000, 0, 0, 0, 0, 0, 0, 0), '0, lat);
    check("fresh_yre", y_re, pk(1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
